pc_gen: RTL and testbench

Parametrised fetch-stage program-counter generator, the successor to the fixed 32-bit PC register. It holds the fetch PC and selects the next PC from reset, trap, execute-stage redirect, stall hold, branch-target-buffer (BTB) prediction, or the sequential PC+4. It sits at the head of the IF stage, drives the instruction memory address, and passes the predicted-taken information down the pipe so that EX can detect mispredictions.

---
 rtl/pc_gen.sv | 147 ++++++++++++++
 tb/tb_pc_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen -- fetch-stage program-counter generator.
//
// Holds the fetch PC and selects the next one from, highest priority first:
// reset vector, trap vector, EX-stage redirect, stall hold, BTB prediction,
// sequential PC+4. Trap and redirect targets are word-aligned on load.
//
// Optional feature macro: PC_BTB_EN
//   defined   -> direct-mapped branch-target buffer (BTB_DEPTH entries) looked
//                up combinationally on pc_if and written on the clock edge
//                (read-before-write on an index collision).
//   undefined -> no BTB storage; pred_taken_if = 0,
//                pred_target_if = pc_plus_four_if, btb_update_* ignored.
//
// Parameters:
//   XLEN          PC width (>= 8)
//   RESET_VECTOR  PC loaded on reset (bits [1:0] zero)
//   BTB_DEPTH     BTB entries (power of two, >= 2)
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   stall_if                   hold the current PC
//   redirect_ex/redirect_pc_ex EX-stage correction and its target
//   trap_en/trap_pc            trap entry and its vector
//   btb_update_*               resolved-branch write into the BTB
//   pc_if, pc_plus_four_if     current fetch PC and PC+4 (wraps)
//   pred_taken_if              BTB predicts taken for pc_if
//   pred_target_if             predicted next PC
//   fetch_valid_if             pc_if is a valid fetch address
// ----------------------------------------------------------------------------
module pc_gen #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     BTB_DEPTH    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_if,
   input  logic            redirect_ex,
   input  logic [XLEN-1:0] redirect_pc_ex,
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            btb_update_en,
   input  logic [XLEN-1:0] btb_update_pc,
   input  logic [XLEN-1:0] btb_update_target,
   input  logic            btb_update_taken,
   output logic [XLEN-1:0] pc_if,
   output logic [XLEN-1:0] pc_plus_four_if,
   output logic            pred_taken_if,
   output logic [XLEN-1:0] pred_target_if,
   output logic            fetch_valid_if
);

   localparam int unsigned IDX  = $clog2(BTB_DEPTH);
   localparam int unsigned TAGW = XLEN - IDX - 2;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            fetch_valid_q;
   logic [XLEN-1:0] pc_plus_four;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;

   assign pc_plus_four = pc_q + XLEN'(4);

`ifdef PC_BTB_EN
   // ---------------------------------------------------------------------
   // Branch-target buffer
   // ---------------------------------------------------------------------
   logic [BTB_DEPTH-1:0] btb_valid_q;
   logic [TAGW-1:0]      btb_tag_q    [BTB_DEPTH];
   logic [XLEN-3:0]      btb_target_q [BTB_DEPTH];
   logic [BTB_DEPTH-1:0] btb_taken_q;

   logic [IDX-1:0]  rd_idx, wr_idx;
   logic [TAGW-1:0] rd_tag, wr_tag;
   logic            btb_hit;

   assign rd_idx = pc_q[IDX+1:2];
   assign rd_tag = pc_q[XLEN-1:IDX+2];
   assign wr_idx = btb_update_pc[IDX+1:2];
   assign wr_tag = btb_update_pc[XLEN-1:IDX+2];

   // Lookup reads the registered array, so a same-cycle write to the same
   // index is seen only from the next cycle.
   assign btb_hit     = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
   assign pred_taken  = btb_hit && btb_taken_q[rd_idx];
   assign pred_target = pred_taken ? {btb_target_q[rd_idx], 2'b00} : pc_plus_four;

   // Only valid bits are reset; tag/target/taken are qualified by valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         btb_valid_q <= '0;
      end else if (btb_update_en) begin
         btb_valid_q[wr_idx]  <= 1'b1;
         btb_tag_q[wr_idx]    <= wr_tag;
         btb_target_q[wr_idx] <= btb_update_target[XLEN-1:2];
         btb_taken_q[wr_idx]  <= btb_update_taken;
      end
   end

   logic unused_lsbs;
   assign unused_lsbs = ^{btb_update_pc[1:0], btb_update_target[1:0],
                          trap_pc[1:0], redirect_pc_ex[1:0]};
`else
   assign pred_taken  = 1'b0;
   assign pred_target = pc_plus_four;

   logic unused_btb;
   assign unused_btb = ^{btb_update_en, btb_update_pc, btb_update_target,
                         btb_update_taken, trap_pc[1:0], redirect_pc_ex[1:0]};
`endif

   // ---------------------------------------------------------------------
   // Next-PC selection
   // ---------------------------------------------------------------------
   always_comb begin
      pc_d = pc_plus_four;
      if (rst) begin
         pc_d = RESET_VECTOR;
      end else if (trap_en) begin
         pc_d = {trap_pc[XLEN-1:2], 2'b00};
      end else if (redirect_ex) begin
         pc_d = {redirect_pc_ex[XLEN-1:2], 2'b00};
      end else if (stall_if) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = pred_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_VECTOR;
         fetch_valid_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         fetch_valid_q <= 1'b1;
      end
   end

   assign pc_if           = pc_q;
   assign pc_plus_four_if = pc_plus_four;
   assign pred_taken_if   = pred_taken;
   assign pred_target_if  = pred_target;
   assign fetch_valid_if  = fetch_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_pc_gen -- scoreboard bench for pc_gen (XLEN=32, RESET_VECTOR=0x100,
// BTB_DEPTH=8). The driver pushes the hand-computed expected outputs for the
// current cycle into a queue and applies that cycle's inputs; a monitor pops
// and compares on every falling edge.
// ----------------------------------------------------------------------------
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_if, redirect_ex, trap_en;
   logic [31:0] redirect_pc_ex, trap_pc;
   logic        btb_update_en, btb_update_taken;
   logic [31:0] btb_update_pc, btb_update_target;
   logic [31:0] pc_if, pc_plus_four_if, pred_target_if;
   logic        pred_taken_if, fetch_valid_if;

   int checks   = 0;
   int failures = 0;
   int step_no  = 0;

   typedef struct {
      int          step;
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tgt;
      logic        fv;
   } exp_t;

   exp_t exp_q[$];

   pc_gen #(
      .XLEN         (32),
      .RESET_VECTOR (32'h100),
      .BTB_DEPTH    (8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall_if          (stall_if),
      .redirect_ex       (redirect_ex),
      .redirect_pc_ex    (redirect_pc_ex),
      .trap_en           (trap_en),
      .trap_pc           (trap_pc),
      .btb_update_en     (btb_update_en),
      .btb_update_pc     (btb_update_pc),
      .btb_update_target (btb_update_target),
      .btb_update_taken  (btb_update_taken),
      .pc_if             (pc_if),
      .pc_plus_four_if   (pc_plus_four_if),
      .pred_taken_if     (pred_taken_if),
      .pred_target_if    (pred_target_if),
      .fetch_valid_if    (fetch_valid_if)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   task automatic cmp(input string name, input int step, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp("pc_if", e.step, pc_if, e.pc);
         cmp("pc_plus_four_if", e.step, pc_plus_four_if, e.pc + 32'd4);
         cmp("pred_taken_if", e.step, {31'd0, pred_taken_if}, {31'd0, e.pt});
         cmp("pred_target_if", e.step, pred_target_if, e.tgt);
         cmp("fetch_valid_if", e.step, {31'd0, fetch_valid_if}, {31'd0, e.fv});
      end
   end

   // ---------------------------------------------------------------------
   // Driver helpers
   // ---------------------------------------------------------------------
   task automatic clear_inputs();
      rst = 1'b0; stall_if = 1'b0; redirect_ex = 1'b0; trap_en = 1'b0;
      redirect_pc_ex = '0; trap_pc = '0;
      btb_update_en = 1'b0; btb_update_pc = '0; btb_update_target = '0;
      btb_update_taken = 1'b0;
   endtask

   // Expected outputs for the cycle currently in progress.
   task automatic expect_now(input logic [31:0] pc, input logic pt,
                             input logic [31:0] tgt, input logic fv);
      exp_t e;
      e.step = step_no; e.pc = pc; e.pt = pt; e.tgt = tgt; e.fv = fv;
      exp_q.push_back(e);
   endtask

   // Not predicted: target is PC+4.
   task automatic expect_seq(input logic [31:0] pc, input logic fv);
      expect_now(pc, 1'b0, pc + 32'd4, fv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_inputs();
      step_no++;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_ex = 1'b1; redirect_pc_ex = tgt;
   endtask

   task automatic btb_write(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk);
      btb_update_en = 1'b1; btb_update_pc = pc;
      btb_update_target = tgt; btb_update_taken = tk;
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();

      // Reset held a second cycle, then release.
      expect_seq(32'h100, 1'b0); rst = 1'b1;              tick();
      expect_seq(32'h100, 1'b0);                          tick();
      expect_seq(32'h104, 1'b1);                          tick();
      expect_seq(32'h108, 1'b1); redirect(32'h21);        tick();
      // Stall three cycles, then stall+redirect (target misaligned).
      expect_seq(32'h20, 1'b1);  stall_if = 1'b1;         tick();
      expect_seq(32'h20, 1'b1);  stall_if = 1'b1;         tick();
      expect_seq(32'h20, 1'b1);  stall_if = 1'b1;         tick();
      expect_seq(32'h20, 1'b1);  stall_if = 1'b1; redirect(32'h203); tick();
      // Trap beats redirect.
      expect_seq(32'h200, 1'b1); trap_en = 1'b1; trap_pc = 32'h80;
      redirect(32'h40);                                   tick();
      // Wrap-around.
      expect_seq(32'h80, 1'b1);  redirect(32'hFFFF_FFFC); tick();
      expect_seq(32'hFFFF_FFFC, 1'b1);                    tick();
      expect_seq(32'h0, 1'b1);                            tick();
      // Reset mid-stall.
      expect_seq(32'h4, 1'b1);   stall_if = 1'b1; rst = 1'b1; tick();
      expect_seq(32'h100, 1'b0);                          tick();

`ifdef PC_BTB_EN
      // Train 0x10 -> 0x300 taken (target LSBs dropped), then walk into it.
      expect_seq(32'h104, 1'b1); btb_write(32'h10, 32'h301, 1'b1);
      redirect(32'h08);                                   tick();
      expect_seq(32'h08, 1'b1);                           tick();
      expect_seq(32'h0C, 1'b1);                           tick();
      expect_now(32'h10, 1'b1, 32'h300, 1'b1);            tick();
      // Alias: 0x30 shares index 4 but not the tag.
      expect_seq(32'h300, 1'b1); redirect(32'h30);        tick();
      expect_seq(32'h30, 1'b1);  redirect(32'h10);        tick();
      // Collision: retrain not-taken while looking up 0x10; old entry wins.
      expect_now(32'h10, 1'b1, 32'h300, 1'b1);
      btb_write(32'h10, 32'h400, 1'b0);                   tick();
      expect_seq(32'h300, 1'b1); redirect(32'h10);        tick();
      expect_seq(32'h10, 1'b1);                           tick();
      // Reset clears the BTB and a concurrent update is ignored.
      expect_seq(32'h14, 1'b1);  rst = 1'b1;
      btb_write(32'h10, 32'h500, 1'b1);                   tick();
      expect_seq(32'h100, 1'b0); redirect(32'h10);        tick();
      expect_seq(32'h10, 1'b1);                           tick();
`else
      // No BTB: random updates never produce a prediction.
      expect_seq(32'h104, 1'b1); btb_write(32'h10, 32'h300, 1'b1);
      redirect(32'h0C);                                   tick();
      for (int i = 0; i < 20; i++) begin
         expect_seq(32'h0C + 32'(4 * i), 1'b1);
         btb_write({$urandom_range(0, 15), 2'b00}, $urandom, 1'b1);
         tick();
      end
`endif

      // Drain the scoreboard (bounded).
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
